// File: rtl/round_pkg.sv
// Shared types for the pipelined multi-mode rounder.
// Holds the mode encoding and the stage-1 control payload.
package round_pkg;

    localparam int STAGES = 2;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } round_mode_e;

    // Kept magnitude lives beside this struct because its width is a module parameter.
    typedef struct packed {
        logic sign;
        logic r;
        logic s;
        logic inc;
    } s1_ctrl_t;

endpackage

// File: rtl/round_decide.sv
// Combinational increment decision for one value, given mode, sign and L/R/S bits.
// Unassigned mode codes fall back to round-to-nearest-even.
module round_decide
    import round_pkg::*;
(
    input  round_mode_e mode,
    input  logic        sign,
    input  logic        l,
    input  logic        r,
    input  logic        s,
    output logic        inc
);

    always_comb begin
        inc = 1'b0;
        case (mode)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (r | s);
            RM_RUP:  inc = !sign & (r | s);
            RM_RMM:  inc = r;
            default: inc = r & (s | l);
        endcase
    end

endmodule

// File: rtl/round_pipe_multimode.sv
// Two-stage valid/ready rounder: stage 1 splits kept/round/sticky and decides the
// increment, stage 2 adds it, handles overflow and holds the output under backpressure.
module round_pipe_multimode
    import round_pkg::*;
#(
    parameter int N        = 24,
    parameter int EXTRA    = 3,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic               InSign,
    input  logic [N+EXTRA-1:0] InMag,
    input  logic [2:0]         InMode,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               OutSign,
    output logic [N-1:0]       OutMag,
    output logic               OutOverflow,
    output logic               OutInexact,
    input  logic               CntClear,
    output logic [CNT_W-1:0]   InexactCount
);

    if (EXTRA < 2) begin : g_bad_extra
        $error("EXTRA must be at least 2");
    end

    logic [STAGES:1] vld_pipe;
    logic            s2_adv;
    logic            in_acc;
    logic            out_xfer;

    assign OutValid = vld_pipe[2];
    assign s2_adv   = !vld_pipe[2] | OutReady;
    assign InReady  = !vld_pipe[1] | s2_adv;
    assign in_acc   = InValid & InReady;
    assign out_xfer = vld_pipe[2] & OutReady;

    // Stage 1 input split
    logic [N-1:0] kept_in;
    s1_ctrl_t     ctrl_in;
    logic         inc_in;

    assign kept_in = InMag[N+EXTRA-1:EXTRA];

    round_decide u_decide (
        .mode (round_mode_e'(InMode)),
        .sign (InSign),
        .l    (kept_in[0]),
        .r    (InMag[EXTRA-1]),
        .s    (|InMag[EXTRA-2:0]),
        .inc  (inc_in)
    );

    always_comb begin
        ctrl_in      = '0;
        ctrl_in.sign = InSign;
        ctrl_in.r    = InMag[EXTRA-1];
        ctrl_in.s    = |InMag[EXTRA-2:0];
        ctrl_in.inc  = inc_in;
    end

    logic [N-1:0] s1_kept;
    s1_ctrl_t     s1_ctrl;

    // Stage 2 add: carry out of N bits is the overflow
    logic [N:0]   sum_ext;
    logic [N-1:0] mag_nxt;

    assign sum_ext = {1'b0, s1_kept} + (N+1)'(s1_ctrl.inc);

    always_comb begin
        mag_nxt = sum_ext[N-1:0];
        if (sum_ext[N])
            mag_nxt = SATURATE ? '1 : '0;
    end

    // An empty or draining S1 may take a new value; S2 loads whenever it is free or consumed.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            vld_pipe    <= '0;
            s1_kept     <= '0;
            s1_ctrl     <= '0;
            OutSign     <= 1'b0;
            OutMag      <= '0;
            OutOverflow <= 1'b0;
            OutInexact  <= 1'b0;
        end else begin
            if (InReady) begin
                vld_pipe[1] <= InValid;
                if (in_acc) begin
                    s1_kept <= kept_in;
                    s1_ctrl <= ctrl_in;
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    OutSign     <= s1_ctrl.sign;
                    OutMag      <= mag_nxt;
                    OutOverflow <= sum_ext[N];
                    OutInexact  <= s1_ctrl.r | s1_ctrl.s;
                end
            end
        end
    end

    // Clear beats a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            InexactCount <= '0;
        else if (CntClear)
            InexactCount <= '0;
        else if (out_xfer && OutInexact && (InexactCount != '1))
            InexactCount <= InexactCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_round_pipe_multimode.sv
// Randomized and directed bench for round_pipe_multimode against an arithmetic rounding model.
// Three instances share stimulus: default, wrap-on-overflow, and a 2-bit counter.
module tb_round_pipe_multimode;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InSign;
    logic [10:0] InMag;
    logic [2:0]  InMode;
    logic        OutReady;
    logic        CntClear;

    logic        InReady, OutValid, OutSign, OutOverflow, OutInexact;
    logic [7:0]  OutMag;
    logic [15:0] InexactCount;

    logic        b_in_ready, b_out_valid, b_sign, b_ovf, b_inex;
    logic [7:0]  b_mag;
    logic [15:0] b_cnt;

    logic        c_in_ready, c_out_valid, c_sign, c_ovf, c_inex;
    logic [7:0]  c_mag;
    logic [1:0]  c_cnt;

    always #5 Clock = ~Clock;

    round_pipe_multimode #(.N(8), .EXTRA(3), .SATURATE(1'b1), .CNT_W(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InSign(InSign), .InMag(InMag), .InMode(InMode), .OutValid(OutValid),
        .OutReady(OutReady), .OutSign(OutSign), .OutMag(OutMag),
        .OutOverflow(OutOverflow), .OutInexact(OutInexact), .CntClear(CntClear),
        .InexactCount(InexactCount));

    round_pipe_multimode #(.N(8), .EXTRA(3), .SATURATE(1'b0), .CNT_W(16)) dut_wrap (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(b_in_ready),
        .InSign(InSign), .InMag(InMag), .InMode(InMode), .OutValid(b_out_valid),
        .OutReady(OutReady), .OutSign(b_sign), .OutMag(b_mag),
        .OutOverflow(b_ovf), .OutInexact(b_inex), .CntClear(CntClear),
        .InexactCount(b_cnt));

    round_pipe_multimode #(.N(8), .EXTRA(3), .SATURATE(1'b1), .CNT_W(2)) dut_cnt2 (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(c_in_ready),
        .InSign(InSign), .InMag(InMag), .InMode(InMode), .OutValid(c_out_valid),
        .OutReady(OutReady), .OutSign(c_sign), .OutMag(c_mag),
        .OutOverflow(c_ovf), .OutInexact(c_inex), .CntClear(CntClear),
        .InexactCount(c_cnt));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rounding from the arithmetic definition: kept = mag/8, frac = mag%8, half = 4.
    function automatic logic [9:0] ref_round(input logic sg, input logic [10:0] m,
                                             input logic [2:0] md, input bit sat);
        int kept, frac, inc, sum;
        logic [7:0] mag;
        kept = int'(m) / 8;
        frac = int'(m) % 8;
        case (md)
            3'd1:    inc = 0;
            3'd2:    inc = (sg && frac != 0) ? 1 : 0;
            3'd3:    inc = (!sg && frac != 0) ? 1 : 0;
            3'd4:    inc = (frac >= 4) ? 1 : 0;
            default: inc = (frac > 4 || (frac == 4 && kept % 2 == 1)) ? 1 : 0;
        endcase
        sum = kept + inc;
        if (sum > 255) mag = sat ? 8'd255 : 8'd0;
        else           mag = 8'(sum);
        return {sum > 255, frac != 0, mag};
    endfunction

    typedef struct {
        int          acc;
        logic        sign;
        logic [10:0] mag;
        logic [2:0]  mode;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   cnt_m = 0;
    int   cntc_m = 0;
    bit   acc_flag = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard: the queue holds every accepted, undelivered transaction in order.
    always @(negedge Clock) begin
        txn_t        e;
        logic [9:0]  ex, exw;
        bit          pop_inex;
        if (cyc > 0) begin
            chk("in_ready", InReady, (q.size() < 2) || OutReady);
            chk("out_valid", OutValid, (q.size() > 0) && (cyc >= q[0].acc + 1));
            chk("count", InexactCount, cnt_m);
            chk("count_cnt2", c_cnt, cntc_m);
            pop_inex = 1'b0;
            if (Reset_n && OutValid && OutReady) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e   = q.pop_front();
                    ex  = ref_round(e.sign, e.mag, e.mode, 1'b1);
                    exw = ref_round(e.sign, e.mag, e.mode, 1'b0);
                    chk("sign", OutSign, e.sign);
                    chk("mag", OutMag, ex[7:0]);
                    chk("ovf", OutOverflow, ex[9]);
                    chk("inexact", OutInexact, ex[8]);
                    chk("mag_wrap", b_mag, exw[7:0]);
                    chk("ovf_wrap", b_ovf, exw[9]);
                    pop_inex = ex[8];
                end
            end
            acc_flag = Reset_n && InValid && InReady;
            if (acc_flag) begin
                e.acc = cyc + 1; e.sign = InSign; e.mag = InMag; e.mode = InMode;
                q.push_back(e);
            end
            if (!Reset_n || CntClear) begin
                cnt_m = 0; cntc_m = 0;
            end else if (pop_inex) begin
                if (cnt_m < 65535) cnt_m++;
                if (cntc_m < 3) cntc_m++;
            end
            if (!Reset_n) q.delete();
        end
    end

    task automatic send(input logic sg, input logic [10:0] m, input logic [2:0] md);
        int guard;
        guard = 0;
        InValid = 1'b1; InSign = sg; InMag = m; InMode = md;
        do begin
            @(posedge Clock);
            guard++;
        end while (!acc_flag && guard < 200);
        if (guard >= 200) chk("send_timeout", 0, 1);
        #1;
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) @(posedge Clock);
        #1;
    endtask

    bit rnd_done;

    initial begin
        Reset_n = 1'b0; InValid = 1'b0; InSign = 1'b0; InMag = '0; InMode = '0;
        OutReady = 1'b1; CntClear = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1'b1;
        idle(2);

        // Tie-to-even, directed modes, RMM tie, overflow, unassigned code
        send(0, 11'b00000101_100, 3'd0);
        send(0, 11'b00000100_100, 3'd0);
        send(0, 11'b00000100_000, 3'd0);
        send(0, 11'b00000100_011, 3'd3);
        send(0, 11'b00000100_011, 3'd2);
        send(1, 11'b00000100_011, 3'd2);
        send(1, 11'b00000100_011, 3'd3);
        send(0, 11'b00000100_011, 3'd1);
        send(1, 11'b00000100_011, 3'd1);
        send(0, 11'b00000100_100, 3'd4);
        send(0, 11'b11111111_110, 3'd0);
        send(1, 11'b11111111_100, 3'd6);
        idle(4);

        // Backpressure: third value stalls until the output is released
        OutReady = 1'b0;
        fork
            begin
                send(0, {8'd1, 3'b000}, 3'd0);
                send(0, {8'd2, 3'b000}, 3'd0);
                send(0, {8'd3, 3'b000}, 3'd0);
                InValid = 1'b0;
            end
            begin
                repeat (5) @(posedge Clock);
                #1 OutReady = 1'b1;
            end
        join
        idle(4);

        // Counter: 5 inexact + 3 exact, then 6 inexact for the 2-bit counter
        CntClear = 1'b1; idle(1); CntClear = 1'b0;
        for (int i = 0; i < 5; i++) send(0, {8'(i + 10), 3'b101}, 3'd0);
        for (int i = 0; i < 3; i++) send(0, {8'(i + 20), 3'b000}, 3'd0);
        idle(5);
        chk("cnt_5_of_8", InexactCount, 5);
        CntClear = 1'b1; idle(1); CntClear = 1'b0;
        for (int i = 0; i < 6; i++) send(1, {8'(i + 30), 3'b010}, 3'd2);
        idle(5);
        chk("cnt_6", InexactCount, 6);
        chk("cnt2_sat", c_cnt, 3);

        // Clear on the same edge as an inexact output transfer
        send(0, 11'b00000111_111, 3'd0);
        InValid = 1'b0;
        @(posedge Clock); #1 CntClear = 1'b1;
        @(posedge Clock); #1 CntClear = 1'b0;
        chk("clear_wins", InexactCount, 0);
        idle(3);

        // Reset with two transactions in flight
        send(0, 11'b00001000_101, 3'd0);
        idle(4);
        OutReady = 1'b0;
        send(0, {8'd40, 3'b001}, 3'd0);
        send(0, {8'd41, 3'b001}, 3'd0);
        InValid = 1'b0; Reset_n = 1'b0;
        @(posedge Clock); #1 Reset_n = 1'b1;
        chk("rst_out_valid", OutValid, 0);
        chk("rst_count", InexactCount, 0);
        chk("rst_in_ready", InReady, 1);
        OutReady = 1'b1;
        idle(6);

        // Random traffic with random backpressure and occasional clears
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(1'($urandom), 11'($urandom), 3'($urandom_range(0, 7)));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge Clock);
                    #1;
                    OutReady = ($urandom_range(0, 3) != 0);
                    CntClear = ($urandom_range(0, 40) == 0);
                end
            end
        join
        OutReady = 1'b1; CntClear = 1'b0;
        idle(6);
        chk("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
